cpu_run_ctrl: RTL and testbench
===============================

// Module: cpu_run_ctrl
// PURPOSE
//   Board-level execution controller for the CPU: generates a one-cycle clock-enable tick that
//   replaces the fixed free-running divider, with HALT / RUN / single-STEP / BREAK modes driven by
//   debounced push-buttons, run speed selected by switches, and a PC breakpoint. Sits in the top
//   level between the board inputs and the cpu/memory enable; pc from the CPU feeds the breakpoint.
// PARAMETERS
//   DIVISOR          50000000  base tick period in clk cycles (speed 0)
//   DEBOUNCE_CYCLES  500000    consecutive stable samples before a button level is accepted
//   ADDR_WIDTH       6         width of pc / bp_addr
//   CNT_WIDTH        16        width of tick_count
// PORTS
//   clk          in   1           system clock
//   rst_n        in   1           asynchronous active-low reset
//   btn          in   3           raw buttons, active-high: [0] run/halt, [1] step, [2] clear break
//   speed_sel    in   2           tick period = max(1, DIVISOR >> (2*speed_sel))
//   pc           in   ADDR_WIDTH  current CPU program counter
//   bp_addr      in   ADDR_WIDTH  breakpoint address
//   bp_en        in   1           breakpoint enable
//   tick         out  1           one-cycle CPU enable pulse
//   mode         out  2           current state (HALT/RUN/STEP/BREAK encoding)
//   bp_hit       out  1           high while in BREAK
//   tick_count   out  CNT_WIDTH   number of ticks issued, wraps at 2^CNT_WIDTH
// BEHAVIOUR
//   Reset (async, rst_n=0): tick=0, mode=HALT, bp_hit=0, tick_count=0, divider=0, debouncers
//     cleared to released, resume flag=0. All outputs registered.
//   Button path, per button: 2-FF synchroniser -> debouncer (level accepted after DEBOUNCE_CYCLES
//     equal samples, counter restarts on any change) -> rising-edge detect -> 1-cycle press pulse.
//     Press-to-pulse latency = 2 + DEBOUNCE_CYCLES + 1 cycles. Holding a button gives one pulse.
//   Divider: counts 0..P-1 while in RUN, cleared on entry to RUN and on any speed_sel change
//     (speed_sel registered; change takes effect next cycle). Period P computed in ADDR-independent
//     32-bit arithmetic; P=0 is forced to 1 (tick every cycle).
//   FSM (press pulses evaluated once per cycle; run beats step beats clear when simultaneous):
//     HALT : run -> RUN; step -> STEP; clear ignored.
//     STEP : tick=1 for exactly this one cycle, then -> HALT (buttons ignored in STEP).
//     RUN  : divider==P-1 -> candidate tick. If bp_en && pc==bp_addr && !resume -> BREAK, tick
//            suppressed; otherwise tick=1 and resume cleared. run press -> HALT, no tick that cycle.
//     BREAK: bp_hit=1. run -> RUN with resume=1 (first tick skips breakpoint check so execution
//            leaves bp_addr); step -> STEP (no breakpoint check); clear -> HALT.
//   Breakpoint compare uses pc sampled in the tick-candidate cycle; bp_en deasserted in BREAK
//     does not leave BREAK.
//   tick_count increments by 1 in every cycle tick=1, wraps to 0 after all-ones.
//   Reset mid-RUN/BREAK returns to HALT immediately with no tick emitted.
// STRUCTURE
//   Shared package cpu_run_ctrl_pkg: 2-bit mode constants MODE_HALT=0, MODE_RUN=1, MODE_STEP=2,
//     MODE_BREAK=3; button index constants BTN_RUN=0, BTN_STEP=1, BTN_CLR=2.
//   One sub-module btn_debounce (sync + debounce + edge pulse, DEBOUNCE_CYCLES parameter),
//     instantiated three times. FSM, divider and counter live in this module.
// TESTING (bench with DIVISOR=16, DEBOUNCE_CYCLES=4)
//   Reset, no buttons for 100 cycles -> tick never high, mode=0, tick_count=0.
//   Press btn[1] held 20 cycles -> exactly one tick, mode goes 2 then 0, tick_count=1.
//   Press btn[0], speed_sel=0 -> ticks every 16 cycles; speed_sel=1 -> every 4; =3 -> every cycle.
//   RUN, bp_en=1, bp_addr=5, pc increments per tick from 0 -> pc reaches 5, no tick, mode=3,
//     bp_hit=1; press btn[0] -> next tick issued at pc=5, runs on; press btn[2] in BREAK -> mode=0.
//   btn[0] and btn[1] pressed together from HALT -> mode=1 (run wins), no single-step tick.
//   Button bouncing (toggle every 2 cycles for 20 cycles, then stable high) -> one press pulse only;
//     rst_n asserted mid-RUN -> tick=0, mode=0, tick_count=0 asynchronously.

Source files
------------

// File: rtl/cpu_run_ctrl_pkg.sv
// Shared definitions for the CPU run controller: mode encoding, button indices,
// and the speed-to-period helper.
package cpu_run_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_HALT  = 2'd0,
        MODE_RUN   = 2'd1,
        MODE_STEP  = 2'd2,
        MODE_BREAK = 2'd3
    } mode_e;

    localparam int BTN_RUN  = 0;
    localparam int BTN_STEP = 1;
    localparam int BTN_CLR  = 2;

    // Each speed step divides the base period by 4; a zero period means tick every cycle.
    function automatic logic [31:0] tick_period(input logic [31:0] divisor,
                                                input logic [1:0]  speed);
        logic [31:0] p;
        p = divisor >> {speed, 1'b0};
        if (p == 32'd0) begin
            p = 32'd1;
        end
        return p;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button path: 2-FF synchroniser, debouncer that accepts a new level after
// DEBOUNCE_CYCLES consecutive differing samples, and a registered rising-edge pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_d;
    logic [CW-1:0] cnt;

    // A sample equal to the accepted level restarts the run, so bounces never accumulate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            level_d <= level;
            press   <= level & ~level_d;
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Execution controller: turns debounced buttons, speed switches and a PC breakpoint
// into a one-cycle CPU enable tick with HALT / RUN / STEP / BREAK modes.
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int DIVISOR         = 50000000,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ADDR_WIDTH      = 6,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2:0]            btn,
    input  logic [1:0]            speed_sel,
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic [ADDR_WIDTH-1:0] bp_addr,
    input  logic                  bp_en,
    output logic                  tick,
    output logic [1:0]            mode,
    output logic                  bp_hit,
    output logic [CNT_WIDTH-1:0]  tick_count
);

    logic [2:0]  press;
    mode_e       state;
    mode_e       state_next;
    logic [1:0]  speed_r;
    logic [31:0] div;
    logic [31:0] period;
    logic        resume;
    logic        resume_next;
    logic        tick_next;
    logic        bp_hit_next;
    logic        run_p;
    logic        step_p;
    logic        clr_p;
    logic        cand;
    logic        bp_match;

    for (genvar i = 0; i < 3; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (btn[i]),
            .press(press[i])
        );
    end

    assign run_p    = press[BTN_RUN];
    assign step_p   = press[BTN_STEP];
    assign clr_p    = press[BTN_CLR];
    assign period   = tick_period(32'(DIVISOR), speed_r);
    assign cand     = (state == MODE_RUN) && (div == period - 32'd1);
    // resume lets the first tick after BREAK step off the breakpoint address.
    assign bp_match = bp_en && (pc == bp_addr) && !resume;
    assign mode     = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= MODE_HALT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            MODE_HALT: begin
                if (run_p) state_next = MODE_RUN;
                else if (step_p) state_next = MODE_STEP;
            end
            MODE_STEP: state_next = MODE_HALT;
            MODE_RUN: begin
                if (run_p) state_next = MODE_HALT;
                else if (cand && bp_match) state_next = MODE_BREAK;
            end
            MODE_BREAK: begin
                if (run_p) state_next = MODE_RUN;
                else if (step_p) state_next = MODE_STEP;
                else if (clr_p) state_next = MODE_HALT;
            end
            default: state_next = MODE_HALT;
        endcase
    end

    always_comb begin
        tick_next   = (state_next == MODE_STEP) ||
                      ((state == MODE_RUN) && !run_p && cand && !bp_match);
        bp_hit_next = (state_next == MODE_BREAK);
        resume_next = 1'b0;
        if ((state == MODE_BREAK) && run_p) begin
            resume_next = 1'b1;
        end else if ((state == MODE_RUN) && (state_next == MODE_RUN) && !tick_next) begin
            resume_next = resume;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick       <= 1'b0;
            bp_hit     <= 1'b0;
            resume     <= 1'b0;
            speed_r    <= 2'd0;
            div        <= 32'd0;
            tick_count <= '0;
        end else begin
            tick       <= tick_next;
            bp_hit     <= bp_hit_next;
            resume     <= resume_next;
            speed_r    <= speed_sel;
            tick_count <= tick_count + {{(CNT_WIDTH-1){1'b0}}, tick_next};
            // Divider restarts on RUN entry, outside RUN and whenever the speed changes.
            if ((state != MODE_RUN) || (state_next != MODE_RUN) || (speed_sel != speed_r)) begin
                div <= 32'd0;
            end else if (div >= period - 32'd1) begin
                div <= 32'd0;
            end else begin
                div <= div + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with a short divider and debounce window.
module tb_cpu_run_ctrl;
    import cpu_run_ctrl_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [2:0]  btn;
    logic [1:0]  speed_sel;
    logic [5:0]  pc;
    logic [5:0]  bp_addr;
    logic        bp_en;
    logic        tick;
    logic [1:0]  mode;
    logic        bp_hit;
    logic [15:0] tick_count;

    int          checks;
    int          errors;
    int          ticks_seen;
    logic [5:0]  last_tick_pc;

    cpu_run_ctrl #(
        .DIVISOR        (16),
        .DEBOUNCE_CYCLES(4),
        .ADDR_WIDTH     (6),
        .CNT_WIDTH      (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn       (btn),
        .speed_sel (speed_sel),
        .pc        (pc),
        .bp_addr   (bp_addr),
        .bp_en     (bp_en),
        .tick      (tick),
        .mode      (mode),
        .bp_hit    (bp_hit),
        .tick_count(tick_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one cycle; a tick advances the modelled CPU program counter.
    task automatic cycle();
        @(negedge clk);
        if (tick === 1'b1) begin
            ticks_seen++;
            last_tick_pc = pc;
            pc = pc + 6'd1;
        end
    endtask

    task automatic press(input logic [2:0] mask);
        btn = mask;
        repeat (10) cycle();
        btn = 3'b000;
        repeat (8) cycle();
    endtask

    task automatic measure_gap(output int gap);
        int t0;
        gap = -1;
        t0 = ticks_seen;
        for (int i = 0; i < 100 && ticks_seen == t0; i++) cycle();
        if (ticks_seen != t0) begin
            t0 = ticks_seen;
            for (int i = 1; i <= 100; i++) begin
                cycle();
                if (ticks_seen != t0) begin
                    gap = i;
                    break;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (mode !== MODE_HALT) begin errors++; $display("FAIL reset_mode: got %0d expected 0", mode); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %0b expected 0", tick); end
        checks++; if (tick_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", tick_count); end
        checks++; if (bp_hit !== 1'b0) begin errors++; $display("FAIL reset_bp_hit: got %0b expected 0", bp_hit); end
        rst_n = 1'b1;
        ticks_seen = 0;
        repeat (100) cycle();
        checks++; if (ticks_seen != 0) begin errors++; $display("FAIL idle_ticks: got %0d expected 0", ticks_seen); end
        checks++; if (mode !== MODE_HALT) begin errors++; $display("FAIL idle_mode: got %0d expected 0", mode); end
        checks++; if (tick_count !== 16'd0) begin errors++; $display("FAIL idle_count: got %0d expected 0", tick_count); end
    endtask

    task automatic test_step();
        int first;
        bit saw_step;
        int bad;
        first = -1; saw_step = 0; bad = 0; ticks_seen = 0;
        btn = 3'b010;
        for (int i = 1; i <= 20; i++) begin
            cycle();
            if (tick === 1'b1 && first < 0) first = i;
            if (mode === MODE_STEP) saw_step = 1;
            if (tick === 1'b1 && mode !== MODE_STEP) bad++;
        end
        btn = 3'b000;
        repeat (10) cycle();
        checks++; if (ticks_seen != 1) begin errors++; $display("FAIL step_ticks: got %0d expected 1", ticks_seen); end
        checks++; if (first != 8) begin errors++; $display("FAIL step_latency: got %0d expected 8", first); end
        checks++; if (!saw_step) begin errors++; $display("FAIL step_mode_seen: got 0 expected 1"); end
        checks++; if (bad != 0) begin errors++; $display("FAIL step_tick_mode: got %0d expected 0", bad); end
        checks++; if (mode !== MODE_HALT) begin errors++; $display("FAIL step_return: got %0d expected 0", mode); end
        checks++; if (tick_count !== 16'd1) begin errors++; $display("FAIL step_count: got %0d expected 1", tick_count); end
    endtask

    task automatic test_run_speeds();
        int gap;
        logic [15:0] c0;
        int all_high;
        speed_sel = 2'd0;
        press(3'b001);
        checks++; if (mode !== MODE_RUN) begin errors++; $display("FAIL run_enter: got %0d expected 1", mode); end
        measure_gap(gap);
        checks++; if (gap != 16) begin errors++; $display("FAIL speed0_gap: got %0d expected 16", gap); end
        measure_gap(gap);
        checks++; if (gap != 16) begin errors++; $display("FAIL speed0_gap2: got %0d expected 16", gap); end
        speed_sel = 2'd1;
        measure_gap(gap);
        checks++; if (gap != 4) begin errors++; $display("FAIL speed1_gap: got %0d expected 4", gap); end
        speed_sel = 2'd3;
        measure_gap(gap);
        checks++; if (gap != 1) begin errors++; $display("FAIL speed3_gap: got %0d expected 1", gap); end
        c0 = tick_count;
        all_high = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (tick === 1'b1) all_high++;
        end
        checks++; if (all_high != 10) begin errors++; $display("FAIL speed3_every: got %0d expected 10", all_high); end
        checks++; if ((tick_count - c0) !== 16'd10) begin errors++; $display("FAIL speed3_count: got %0d expected 10", tick_count - c0); end
        speed_sel = 2'd1;
        press(3'b001);
        checks++; if (mode !== MODE_HALT) begin errors++; $display("FAIL run_halt: got %0d expected 0", mode); end
        ticks_seen = 0;
        repeat (20) cycle();
        checks++; if (ticks_seen != 0) begin errors++; $display("FAIL halt_quiet: got %0d expected 0", ticks_seen); end
    endtask

    task automatic test_breakpoint();
        pc = 6'd0; bp_addr = 6'd5; bp_en = 1'b1; speed_sel = 2'd1;
        ticks_seen = 0;
        btn = 3'b001;
        repeat (10) cycle();
        btn = 3'b000;
        for (int i = 0; i < 200 && mode !== MODE_BREAK; i++) cycle();
        checks++; if (mode !== MODE_BREAK) begin errors++; $display("FAIL bp_mode: got %0d expected 3", mode); end
        checks++; if (bp_hit !== 1'b1) begin errors++; $display("FAIL bp_hit: got %0b expected 1", bp_hit); end
        checks++; if (pc !== 6'd5) begin errors++; $display("FAIL bp_pc: got %0d expected 5", pc); end
        checks++; if (ticks_seen != 5) begin errors++; $display("FAIL bp_ticks: got %0d expected 5", ticks_seen); end
        repeat (12) cycle();
        checks++; if (ticks_seen != 5) begin errors++; $display("FAIL bp_hold_ticks: got %0d expected 5", ticks_seen); end
        bp_en = 1'b0;
        repeat (5) cycle();
        checks++; if (mode !== MODE_BREAK) begin errors++; $display("FAIL bp_en_drop: got %0d expected 3", mode); end
        bp_en = 1'b1;
        ticks_seen = 0;
        btn = 3'b001;
        repeat (10) cycle();
        btn = 3'b000;
        for (int i = 0; i < 50 && ticks_seen == 0; i++) cycle();
        checks++; if (ticks_seen < 1 || last_tick_pc !== 6'd5) begin errors++; $display("FAIL resume_pc: got %0d expected 5 (ticks %0d)", last_tick_pc, ticks_seen); end
        for (int i = 0; i < 100 && pc !== 6'd8; i++) cycle();
        checks++; if (mode !== MODE_RUN || pc !== 6'd8) begin errors++; $display("FAIL run_past_bp: got mode %0d pc %0d expected mode 1 pc 8", mode, pc); end
        pc = 6'd3;
        for (int i = 0; i < 100 && mode !== MODE_BREAK; i++) cycle();
        checks++; if (mode !== MODE_BREAK || pc !== 6'd5) begin errors++; $display("FAIL rebreak: got mode %0d pc %0d expected mode 3 pc 5", mode, pc); end
        press(3'b100);
        checks++; if (mode !== MODE_HALT) begin errors++; $display("FAIL clear_mode: got %0d expected 0", mode); end
        checks++; if (bp_hit !== 1'b0) begin errors++; $display("FAIL clear_bp_hit: got %0b expected 0", bp_hit); end
        bp_en = 1'b0;
    endtask

    task automatic test_run_step_together();
        bit saw_step;
        int bad;
        logic [1:0] mode_at8;
        logic tick_at8;
        saw_step = 0; bad = 0; mode_at8 = 2'd0; tick_at8 = 1'b1;
        btn = 3'b011;
        for (int i = 1; i <= 10; i++) begin
            cycle();
            if (mode === MODE_STEP) saw_step = 1;
            if (tick === 1'b1 && mode !== MODE_RUN) bad++;
            if (i == 8) begin mode_at8 = mode; tick_at8 = tick; end
        end
        btn = 3'b000;
        checks++; if (saw_step) begin errors++; $display("FAIL both_no_step: got 1 expected 0"); end
        checks++; if (bad != 0) begin errors++; $display("FAIL both_step_tick: got %0d expected 0", bad); end
        checks++; if (mode_at8 !== MODE_RUN) begin errors++; $display("FAIL both_mode: got %0d expected 1", mode_at8); end
        checks++; if (tick_at8 !== 1'b0) begin errors++; $display("FAIL both_entry_tick: got %0b expected 0", tick_at8); end
        repeat (8) cycle();
        press(3'b001);
        checks++; if (mode !== MODE_HALT) begin errors++; $display("FAIL both_halt: got %0d expected 0", mode); end
    endtask

    task automatic test_bounce();
        logic [15:0] c0;
        c0 = tick_count;
        ticks_seen = 0;
        for (int i = 0; i < 5; i++) begin
            btn = 3'b010;
            repeat (2) cycle();
            btn = 3'b000;
            repeat (2) cycle();
        end
        btn = 3'b010;
        repeat (20) cycle();
        btn = 3'b000;
        repeat (10) cycle();
        checks++; if (ticks_seen != 1) begin errors++; $display("FAIL bounce_ticks: got %0d expected 1", ticks_seen); end
        checks++; if ((tick_count - c0) !== 16'd1) begin errors++; $display("FAIL bounce_count: got %0d expected 1", tick_count - c0); end
        checks++; if (mode !== MODE_HALT) begin errors++; $display("FAIL bounce_mode: got %0d expected 0", mode); end
    endtask

    task automatic test_reset_mid_run();
        speed_sel = 2'd3;
        press(3'b001);
        checks++; if (mode !== MODE_RUN || tick !== 1'b1) begin errors++; $display("FAIL mid_run_setup: got mode %0d tick %0b expected 1 1", mode, tick); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL async_tick: got %0b expected 0", tick); end
        checks++; if (mode !== MODE_HALT) begin errors++; $display("FAIL async_mode: got %0d expected 0", mode); end
        checks++; if (tick_count !== 16'd0) begin errors++; $display("FAIL async_count: got %0d expected 0", tick_count); end
        repeat (3) cycle();
        rst_n = 1'b1;
        ticks_seen = 0;
        repeat (10) cycle();
        checks++; if (mode !== MODE_HALT || ticks_seen != 0) begin errors++; $display("FAIL post_reset: got mode %0d ticks %0d expected 0 0", mode, ticks_seen); end
    endtask

    initial begin
        checks = 0; errors = 0; ticks_seen = 0; last_tick_pc = 6'd0;
        rst_n = 1'b0; btn = 3'b000; speed_sel = 2'd0;
        pc = 6'd0; bp_addr = 6'd0; bp_en = 1'b0;
        test_reset();
        test_step();
        test_run_speeds();
        test_breakpoint();
        test_run_step_together();
        test_bounce();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
